// File: rtl/pwm_led_multi_pkg.sv
// Shared types and helpers for the multi-channel LED PWM.
// Mode/direction encodings and the counter ceiling function.
package pwm_led_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int unsigned cnt_max(
    input int unsigned width
  );
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_led_multi_if.sv
// Duty write port: valid/ready handshake carrying channel and duty.
// The master drives requests, the PWM block is the slave.
interface pwm_led_multi_if #(
  parameter int CHAN_W = 2,
  parameter int DUTY_W = 8
);

  logic              wr_valid;
  logic              wr_ready;
  logic [CHAN_W-1:0] wr_chan;
  logic [DUTY_W-1:0] wr_duty;

  modport master (
    output wr_valid,
    output wr_chan,
    output wr_duty,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_chan,
    input  wr_duty,
    output wr_ready
  );

endinterface

// File: rtl/pwm_led_multi_prescaler.sv
// Clock prescaler: ticks once every prescale_div+1 enabled cycles.
// Held at 0 while disabled; wraps at once if above a lowered divider.
module pwm_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale_div,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_wrap;

  assign w_wrap = (r_cnt >= prescale_div);
  assign tick   = enable && !rst && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !enable || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_led_multi.sv
// N-channel LED PWM: shared prescaler/counter, shadowed duties.
// Optional per-channel triangle fading under PWM_LED_FADE_EN.
module pwm_led_multi
  import pwm_led_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               center_mode,
  input  logic [PRESC_W-1:0] prescale_div,
  pwm_led_multi_if.slave     wr,
`ifdef PWM_LED_FADE_EN
  input  logic [N_CH-1:0]    fade_en,
`endif
  output logic [N_CH-1:0]    pwm_out,
  output logic               period_start
);

  localparam logic [CNT_W-1:0] MAX =
    CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             w_tick;
  logic             w_wrap;
  logic             w_commit;
  logic             w_wr_en;
  mode_e            r_mode;
  dir_e             r_dir;
  dir_e             w_dir_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_shadow [N_CH];
  logic [CNT_W-1:0] r_active [N_CH];
  logic [N_CH-1:0]  r_pwm;
  logic [N_CH-1:0]  w_pwm_nxt;
  logic             r_pstart;
  logic             r_ready;
`ifdef PWM_LED_FADE_EN
  dir_e             r_fdir [N_CH];
`endif

  pwm_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .prescale_div(prescale_div),
    .tick        (w_tick)
  );

  assign wr.wr_ready   = r_ready;
  assign pwm_out       = r_pwm;
  assign period_start  = r_pstart;
  assign w_commit      = !enable || w_wrap;
  assign w_wr_en       = wr.wr_valid && r_ready &&
                         (int'(wr.wr_chan) < N_CH);

  // Wrap = tick on which cnt returns to 0 heading up.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    if (w_tick) begin
      unique case (r_mode)
        PWM_EDGE: begin
          w_cnt_nxt = r_cnt + ONE;
          w_dir_nxt = DIR_UP;
          w_wrap    = (r_cnt == MAX);
        end
        PWM_CENTER: begin
          if (r_dir == DIR_UP) begin
            if (r_cnt == MAX) begin
              w_cnt_nxt = r_cnt - ONE;
              w_dir_nxt = DIR_DOWN;
            end else begin
              w_cnt_nxt = r_cnt + ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt - ONE;
            if (r_cnt == ONE) begin
              w_dir_nxt = DIR_UP;
              w_wrap    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pwm_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_pwm_nxt[i] = enable && (r_cnt < r_active[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dir    <= DIR_UP;
      r_mode   <= PWM_EDGE;
      r_pwm    <= '0;
      r_pstart <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_pwm   <= w_pwm_nxt;
      if (!enable) begin
        r_cnt    <= '0;
        r_dir    <= DIR_UP;
        r_pstart <= 1'b0;
        r_mode   <= center_mode ? PWM_CENTER : PWM_EDGE;
      end else begin
        r_cnt    <= w_cnt_nxt;
        r_dir    <= w_dir_nxt;
        r_pstart <= w_wrap;
        if (w_wrap) begin
          r_mode <= center_mode ? PWM_CENTER : PWM_EDGE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
`ifdef PWM_LED_FADE_EN
        r_fdir[i]   <= DIR_UP;
`endif
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
`ifdef PWM_LED_FADE_EN
        if (fade_en[i]) begin
          if (w_wrap) begin
            if (r_fdir[i] == DIR_UP) begin
              if (r_active[i] == MAX) begin
                r_active[i] <= MAX - ONE;
                r_fdir[i]   <= DIR_DOWN;
              end else begin
                r_active[i] <= r_active[i] + ONE;
              end
            end else begin
              if (r_active[i] == '0) begin
                r_active[i] <= ONE;
                r_fdir[i]   <= DIR_UP;
              end else begin
                r_active[i] <= r_active[i] - ONE;
              end
            end
          end
        end else if (w_commit) begin
          r_active[i] <= r_shadow[i];
        end
`else
        if (w_commit) begin
          r_active[i] <= r_shadow[i];
        end
`endif
      end
      if (w_wr_en) begin
        r_shadow[wr.wr_chan] <= wr.wr_duty;
      end
    end
  end

endmodule

// File: tb/tb_pwm_led_multi.sv
// Bench for pwm_led_multi: directed periods plus random traffic,
// compared each cycle against a period-position reference model.
module tb_pwm_led_multi;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int PW   = 8;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          center_mode;
  logic [PW-1:0] prescale_div;
  logic [N-1:0]  pwm_out;
  logic          period_start;
`ifdef PWM_LED_FADE_EN
  logic [N-1:0]  fade_en = '0;
`endif

  pwm_led_multi_if #(.CHAN_W(2), .DUTY_W(W)) wr ();

  pwm_led_multi #(
    .N_CH   (N),
    .CNT_W  (W),
    .PRESC_W(PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .center_mode (center_mode),
    .prescale_div(prescale_div),
    .wr          (wr),
`ifdef PWM_LED_FADE_EN
    .fade_en     (fade_en),
`endif
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: position p within the period, ticks every div+1.
  int           m_sh [N];
  int           m_act [N];
  int           m_p;
  int           m_k;
  bit           m_ctr;
  bit           m_ready;
  logic [N-1:0] m_pwm;
  logic         m_ps;

  bit rand_wr;
  int tgt_p [2];
  int tgt_d [2];
  int tgt_idx;
  int tgt_n;
  int g_hi [N];
  int g_len;

  function automatic int plen(input bit c);
    return c ? 2 * MAXV : MAXV + 1;
  endfunction

  function automatic int cnt_of(input int p, input bit c);
    if (c && p > MAXV) return 2 * MAXV - p;
    return p;
  endfunction

  task automatic model_edge();
    int  sh_old [N];
    int  cnt;
    int  d;
    bit  tick;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i]  = 0;
        m_act[i] = 0;
      end
      m_p = 0; m_k = 0; m_ctr = 0;
      m_pwm = '0; m_ps = 0; m_ready = 0;
      return;
    end
    sh_old = m_sh;
    if (!enable) begin
      m_pwm = '0; m_ps = 0;
      m_p = 0; m_k = 0;
      m_ctr = center_mode;
      m_act = sh_old;
    end else begin
      cnt = cnt_of(m_p, m_ctr);
      for (int i = 0; i < N; i++)
        m_pwm[i] = (cnt < m_act[i]);
      d    = int'(prescale_div);
      tick = ((m_k % (d + 1)) == d);
      m_k++;
      m_ps = 0;
      if (tick) begin
        m_p++;
        if (m_p == plen(m_ctr)) begin
          m_p   = 0;
          m_ps  = 1;
          m_act = sh_old;
          m_ctr = center_mode;
        end
      end
    end
    if (wr.wr_valid && m_ready && int'(wr.wr_chan) < N)
      m_sh[wr.wr_chan] = int'(wr.wr_duty);
    m_ready = 1;
  endtask

  task automatic drive_next();
    wr.wr_valid = 1'b0;
    if (tgt_idx < tgt_n && enable &&
        m_p == tgt_p[tgt_idx]) begin
      wr.wr_valid = 1'b1;
      wr.wr_chan  = 2'd3;
      wr.wr_duty  = W'(tgt_d[tgt_idx]);
      tgt_idx++;
    end else if (rand_wr && $urandom_range(0, 7) == 0) begin
      wr.wr_valid = 1'b1;
      wr.wr_chan  = 2'($urandom_range(0, N - 1));
      wr.wr_duty  = W'($urandom_range(0, MAXV));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm", 32'(pwm_out), 32'(m_pwm));
    chk("pstart", 32'(period_start), 32'(m_ps));
    chk("ready", 32'(wr.wr_ready), 32'(m_ready));
    drive_next();
  endtask

  task automatic wr_one(input int ch, input int d);
    wr.wr_valid = 1'b1;
    wr.wr_chan  = 2'(ch);
    wr.wr_duty  = W'(d);
    step();
  endtask

  task automatic wait_pstart(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      step();
      if (period_start) seen = 1;
    end
    chk("pstart_wait", 32'(seen), 32'd1);
  endtask

  // Window: cycle after one pulse through the next pulse.
  task automatic run_period(input int lim);
    bit seen = 0;
    g_len = 0;
    for (int c = 0; c < N; c++) g_hi[c] = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      step();
      g_len++;
      for (int c = 0; c < N; c++)
        g_hi[c] += int'(pwm_out[c]);
      if (period_start) seen = 1;
    end
    chk("period_end", 32'(seen), 32'd1);
  endtask

  function automatic int pick_duty();
    int r = $urandom_range(0, 5);
    if (r == 0) return 0;
    if (r == 1) return MAXV;
    return $urandom_range(0, MAXV);
  endfunction

  initial begin
    int hi0;
    rst          = 1'b1;
    enable       = 1'b0;
    center_mode  = 1'b0;
    prescale_div = '0;
    wr.wr_valid  = 1'b0;
    wr.wr_chan   = '0;
    wr.wr_duty   = '0;
    rand_wr      = 0;
    tgt_idx      = 0;
    tgt_n        = 0;

    repeat (3) step();
    chk("rst_ready", 32'(wr.wr_ready), 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    wr_one(2, 77);
    rst = 1'b0;
    step();
    chk("ready_up", 32'(wr.wr_ready), 32'd1);

    wr_one(0, 64);
    wr_one(1, 255);
    enable = 1'b1;
    wait_pstart(600);
    run_period(600);
    chk("e_len", 32'(g_len), 32'd256);
    chk("e_ch0", 32'(g_hi[0]), 32'd64);
    chk("e_ch1", 32'(g_hi[1]), 32'd255);
    chk("e_ch2", 32'(g_hi[2]), 32'd0);

    enable       = 1'b0;
    prescale_div = 8'd3;
    step();
    wr_one(2, 128);
    enable = 1'b1;
    wait_pstart(2100);
    run_period(2100);
    chk("p_len", 32'(g_len), 32'd1024);
    chk("p_ch2", 32'(g_hi[2]), 32'd512);
    chk("p_ch0", 32'(g_hi[0]), 32'd256);
    chk("p_ch1", 32'(g_hi[1]), 32'd1020);

    enable       = 1'b0;
    prescale_div = '0;
    center_mode  = 1'b1;
    step();
    wr_one(0, 10);
    enable = 1'b1;
    wait_pstart(600);
    run_period(600);
    chk("c_len", 32'(g_len), 32'd510);
    chk("c_ch0", 32'(g_hi[0]), 32'd19);
    chk("c_ch1", 32'(g_hi[1]), 32'd509);
    chk("c_ch2", 32'(g_hi[2]), 32'd255);

    enable      = 1'b0;
    center_mode = 1'b0;
    step();
    wr_one(3, 30);
    enable = 1'b1;
    wait_pstart(600);
    tgt_p   = '{100, 255};
    tgt_d   = '{200, 50};
    tgt_idx = 0;
    tgt_n   = 2;
    run_period(600);
    chk("cm_old", 32'(g_hi[3]), 32'd30);
    run_period(600);
    chk("cm_first", 32'(g_hi[3]), 32'd200);
    run_period(600);
    chk("cm_second", 32'(g_hi[3]), 32'd50);
    chk("cm_fired", 32'(tgt_idx), 32'd2);
    tgt_n = 0;

    enable = 1'b0;
    step();
    wr_one(0, 100);
    enable = 1'b1;
    repeat (150) step();
    rst = 1'b1;
    step();
    chk("mr_pwm", 32'(pwm_out), 32'd0);
    chk("mr_ready", 32'(wr.wr_ready), 32'd0);
    rst = 1'b0;
    hi0 = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      hi0 += int'(pwm_out[0]);
    end
    chk("mr_ch0_dead", 32'(hi0), 32'd0);
    chk("mr_ready_up", 32'(wr.wr_ready), 32'd1);

    rand_wr = 1;
    for (int r = 0; r < 4; r++) begin
      enable       = 1'b0;
      prescale_div = PW'($urandom_range(0, 2));
      center_mode  = 1'($urandom_range(0, 1));
      step();
      for (int c = 0; c < N; c++) wr_one(c, pick_duty());
      enable = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 499) == 0)
          center_mode = ~center_mode;
        enable = ($urandom_range(0, 999) != 0);
        step();
      end
    end
    rand_wr = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
